// File: rtl/aukv_muldiv.sv
// rtl/aukv_muldiv.sv - iterative radix-2 RV32M/RV64M multiply/divide unit
module aukv_muldiv #(
  parameter int XLEN = 32,
  parameter int CNTW = $clog2(XLEN) + 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_rd,
  output logic            o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [CNTW-1:0]     r_cnt;
  logic [2:0]          r_op;
  logic                r_neg_a, r_neg_b;
  logic [XLEN-1:0]     r_opb;   // multiplicand magnitude or divisor magnitude
  logic [2*XLEN-1:0]   r_prod;  // {acc, multiplier} or {remainder, dividend/quotient}
  logic [XLEN-1:0]     r_res;

  // Operand decode at the accept edge
  logic            w_accept, w_is_div, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
  logic            w_div0, w_ovf, w_fast, w_last;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_fast_res;
  logic [XLEN-1:0] w_min;

  assign w_min    = {1'b1, {(XLEN-1){1'b0}}};
  assign w_accept = (r_state == S_IDLE) && i_valid && !i_flush;
  assign w_is_div = i_op[2];
  assign w_sgn_a  = (i_op == 3'd1) || (i_op == 3'd2) || (i_op[2] && !i_op[0]);
  assign w_sgn_b  = (i_op == 3'd1) || (i_op[2] && !i_op[0]);
  assign w_neg_a  = w_sgn_a && i_rs1[XLEN-1];
  assign w_neg_b  = w_sgn_b && i_rs2[XLEN-1];
  assign w_mag_a  = w_neg_a ? (~i_rs1 + 1'b1) : i_rs1;
  assign w_mag_b  = w_neg_b ? (~i_rs2 + 1'b1) : i_rs2;
  assign w_div0   = w_is_div && (i_rs2 == '0);
  assign w_ovf    = w_is_div && !i_op[0] && (i_rs1 == w_min) && (i_rs2 == '1);
  assign w_fast   = w_div0 || w_ovf;
  assign w_fast_res = w_div0 ? (i_op[1] ? i_rs1 : '1)
                             : (i_op[1] ? '0 : i_rs1);
  assign w_last   = (r_cnt == CNTW'(XLEN - 1));

  // One multiply or divide step from the current datapath registers
  logic [XLEN:0]     w_sum, w_shift, w_diff;
  logic [2*XLEN-1:0] w_mul_nxt, w_div_nxt, w_step, w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix, w_rem_fix, w_final;

  assign w_sum     = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, (r_prod[0] ? r_opb : '0)};
  assign w_mul_nxt = {w_sum, r_prod[XLEN-1:1]};
  assign w_shift   = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, r_opb};
  assign w_div_nxt = w_diff[XLEN]
                   ? {w_shift[XLEN-1:0], r_prod[XLEN-2:0], 1'b0}
                   : {w_diff[XLEN-1:0],  r_prod[XLEN-2:0], 1'b1};
  assign w_step    = r_op[2] ? w_div_nxt : w_mul_nxt;

  assign w_prod_fix = (r_neg_a ^ r_neg_b) ? (~w_step + 1'b1) : w_step;
  assign w_quo_fix  = (r_neg_a ^ r_neg_b) ? (~w_step[XLEN-1:0] + 1'b1) : w_step[XLEN-1:0];
  assign w_rem_fix  = r_neg_a ? (~w_step[2*XLEN-1:XLEN] + 1'b1) : w_step[2*XLEN-1:XLEN];
  assign w_final    = r_op[2] ? (r_op[1] ? w_rem_fix : w_quo_fix)
                              : ((r_op == 3'd0) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN]);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (i_valid) w_state_nxt = w_fast ? S_DONE : S_CALC;
        S_CALC:  if (w_last)  w_state_nxt = S_DONE;
        S_DONE:  if (i_ready) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: latch operands on accept, iterate in CALC, capture corrected result
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_op    <= '0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_opb   <= '0;
      r_prod  <= '0;
      r_res   <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_op    <= i_op;
      r_neg_a <= w_neg_a;
      r_neg_b <= w_neg_b;
      r_opb   <= w_is_div ? w_mag_b : w_mag_a;
      r_prod  <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
      r_res   <= w_fast_res;
    end else if (r_state == S_CALC) begin
      r_cnt  <= r_cnt + 1'b1;
      r_prod <= w_step;
      if (w_last) r_res <= w_final;
    end
  end

  assign o_ready = (r_state == S_IDLE);
  assign o_valid = (r_state == S_DONE);
  assign o_busy  = (r_state != S_IDLE);
  assign o_rd    = o_valid ? r_res : '0;

endmodule

// File: doc/aukv_muldiv.md
Name: aukv_muldiv

Overview:
- Parametrised, multi-cycle RV32M/RV64M multiply/divide unit for the Auk-V execute stage. It is the sequential successor to the single-cycle integer ALU.
- Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU with an iterative radix-2 datapath.
- Valid/ready handshakes on both input and output let the pipeline stall around it.
- Supports a flush for squashed instructions and fast-path completion of divide corner cases.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- CNTW, $clog2(XLEN)+1, iteration-counter width; derived, never overridden.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous active-high reset.
- i_flush  input  1  abort the in-flight or held operation.
- i_valid  input  1  operation request.
- o_ready  output  1  unit can accept a request.
- i_op  input  3  RV M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_rs1  input  XLEN  operand A (multiplicand / dividend).
- i_rs2  input  XLEN  operand B (multiplier / divisor).
- o_valid  output  1  result available.
- i_ready  input  1  consumer accepts result.
- o_rd  output  XLEN  result.
- o_busy  output  1  state != IDLE.

Behaviour:
- Reset: async on i_rst rising; state IDLE, counter 0, all datapath registers 0. o_valid=0, o_rd=0, o_busy=0, o_ready=1. Reset mid-operation discards the operation with no output.
- States:
  - IDLE: o_ready=1.
  - CALC: iterating.
  - DONE: o_valid=1; o_rd holds the result.
- Accept: i_valid & o_ready at an edge latches i_op and operands.
  - Signed operands (MULH rs1/rs2, MULHSU rs1 only, DIV/REM both) are converted to magnitude; the sign flags are stored.
- Fast path, divide only, decided at accept:
  - Divisor 0: quotient all-ones; remainder = i_rs1 (raw).
  - DIV/REM with rs1 = most-negative and rs2 = -1: quotient = rs1; remainder = 0.
  - Both go IDLE->DONE in one edge, so o_valid rises 1 cycle after accept.
- Normal path: IDLE->CALC, counter=0.
  - Each CALC cycle performs one step and increments the counter.
  - Multiply step: shift-add into a 2*XLEN product register.
  - Divide step: restoring shift-subtract producing an XLEN quotient and remainder.
  - After the XLEN-th step, move to DONE and apply the final sign correction in the same edge.
    - Product negated if the stored signs differ.
    - Quotient negated if the dividend and divisor signs differ.
    - Remainder takes the dividend's sign.
  - o_valid rises exactly XLEN+1 cycles after the accept edge (33 for XLEN=32).
- Result select: MUL = low XLEN bits; MULH/MULHSU/MULHU = high XLEN bits; DIV/DIVU = quotient; REM/REMU = remainder.
- DONE: o_rd and o_valid stay stable while i_ready=0.
  - o_valid & i_ready at an edge moves to IDLE; o_valid=0 next cycle.
  - No new accept in the same cycle, because o_ready=0 in DONE.
- Flush: i_flush=1 at an edge forces IDLE from any state.
  - o_valid=0 next cycle; the result is dropped.
  - A request with i_valid & i_flush in IDLE is not accepted. Flush has priority over accept and over the output handshake.
- o_rd is 0 whenever o_valid=0.
- Input changes outside the accept edge are ignored.

Test Plan:
- MUL 7 * 0xFFFFFFFD (-3) -> o_rd=0xFFFFFFEB; o_valid rises 33 cycles after accept.
- MULH 0x80000000 * 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0. All with o_valid 1 cycle after accept.
- Backpressure and flush:
  - i_ready=0 for 10 cycles in DONE -> o_rd/o_valid stable and o_ready=0. i_ready=1 -> IDLE, o_ready=1 next cycle.
  - i_flush pulsed at CALC cycle 12 -> o_valid never asserts; o_ready=1 next cycle. A following MULHU completes correctly.
- i_rst asserted mid-CALC, asynchronously between edges -> o_busy, o_valid, o_rd drop to 0 immediately. After release, DIV 20/4=5 is correct.
